// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the trace line checker.
//   - FSM state encoding for the line parser
//   - format_type codes and error_code bit positions
//   - ASCII constants for the trace grammar
//   - char_class_t: per-character classification returned by trace_char_class
//   - dec_width(): bit width that holds an n-digit decimal number
package trace_pkg;

    typedef enum logic [3:0] {
        IDLE,
        TIME,
        PC,
        COLON_SP,
        GRF,
        ADDR,
        SP_LT,
        EQ,
        DATA_SP,
        DATA,
        DONE
    } state_t;

    localparam logic [1:0] FORMAT_NONE = 2'd0;
    localparam logic [1:0] FORMAT_REG  = 2'd1;
    localparam logic [1:0] FORMAT_MEM  = 2'd2;

    localparam int ERR_PC_ALIGN = 0;
    localparam int ERR_PC_RANGE = 1;
    localparam int ERR_MEM      = 2;
    localparam int ERR_GRF      = 3;

    localparam logic [7:0] CH_CARET  = 8'h5e; // ^
    localparam logic [7:0] CH_AT     = 8'h40; // @
    localparam logic [7:0] CH_COLON  = 8'h3a; // :
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_DOLLAR = 8'h24; // $
    localparam logic [7:0] CH_STAR   = 8'h2a; // *
    localparam logic [7:0] CH_LT     = 8'h3c; // <
    localparam logic [7:0] CH_EQ     = 8'h3d; // =
    localparam logic [7:0] CH_HASH   = 8'h23; // #
    localparam logic [7:0] CH_0      = 8'h30;
    localparam logic [7:0] CH_9      = 8'h39;
    localparam logic [7:0] CH_A_LO   = 8'h61; // a
    localparam logic [7:0] CH_F_LO   = 8'h66; // f

    typedef struct packed {
        logic       is_dec;
        logic       is_hex;
        logic       is_space;
        logic [3:0] nibble;
    } char_class_t;

    function automatic int dec_width(input int n);
        return $clog2(10 ** n);
    endfunction

endpackage

// File: rtl/trace_char_class.sv
// trace_char_class: combinational classification of one ASCII character.
// Ports:
//   char  in   8  ASCII character
//   cls   out     is_dec (0-9), is_hex (0-9, a-f only), is_space, nibble value
// Uppercase hex is deliberately not recognised.
module trace_char_class
    import trace_pkg::*;
(
    input  logic [7:0]  char,
    output char_class_t cls
);

    always_comb begin
        cls          = '0;
        cls.is_space = (char == CH_SPACE);
        if (char >= CH_0 && char <= CH_9) begin
            cls.is_dec = 1'b1;
            cls.is_hex = 1'b1;
            cls.nibble = char[3:0];
        end else if (char >= CH_A_LO && char <= CH_F_LO) begin
            cls.is_hex = 1'b1;
            // 'a' is 0x61, so the low nibble plus 9 gives 10..15
            cls.nibble = char[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/trace_line_checker.sv
// trace_line_checker: streaming parser/checker for CPU trace lines, one ASCII
// character per clock:
//   ^<time>@<pc>: $<grf> <= <data>#      register write
//   ^<time>@<pc>: *<addr> <= <data>#     memory write
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   char               ASCII character consumed every rising edge
//   format_type        0 none, 1 register write, 2 memory write (one-cycle pulse)
//   error_code         semantic error bits, valid while format_type != 0
//   time_o/pc_o/grf_o/addr_o/data_o  fields of the last accepted line
// Build option: TRACE_CHECK_EN enables the range/alignment comparators;
// without it error_code is constant 0 and parsing is unchanged.
module trace_line_checker
    import trace_pkg::*;
#(
    parameter  int          TIME_DIGITS = 4,
    parameter  int          GRF_DIGITS  = 4,
    parameter  int          HEX_DIGITS  = 8,
    parameter  int unsigned PC_LO       = 'h3000,
    parameter  int unsigned PC_HI       = 'h6fff,
    parameter  int unsigned ADDR_LO     = 'h0,
    parameter  int unsigned ADDR_HI     = 'h2fff,
    localparam int          TW          = dec_width(TIME_DIGITS),
    localparam int          GW          = dec_width(GRF_DIGITS),
    localparam int          HW          = 4 * HEX_DIGITS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    char,
    output logic [1:0]    format_type,
    output logic [3:0]    error_code,
    output logic [TW-1:0] time_o,
    output logic [HW-1:0] pc_o,
    output logic [GW-1:0] grf_o,
    output logic [HW-1:0] addr_o,
    output logic [HW-1:0] data_o
);

    localparam int MAXD = (TIME_DIGITS > GRF_DIGITS)
                        ? ((TIME_DIGITS > HEX_DIGITS) ? TIME_DIGITS : HEX_DIGITS)
                        : ((GRF_DIGITS  > HEX_DIGITS) ? GRF_DIGITS  : HEX_DIGITS);
    localparam int CW   = $clog2(MAXD + 1);

    localparam logic [CW-1:0] TIME_MAX = CW'(TIME_DIGITS);
    localparam logic [CW-1:0] GRF_MAX  = CW'(GRF_DIGITS);
    localparam logic [CW-1:0] HEX_CNT  = CW'(HEX_DIGITS);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] time_acc;
    logic [GW-1:0] grf_acc;
    logic [HW-1:0] pc_acc, addr_acc, data_acc;
    logic          is_mem_q;

    logic clr, cnt_clr, set_mem, load;
    logic acc_time, acc_grf, acc_pc, acc_addr, acc_data, acc_any;
    logic [3:0] err_d;

    char_class_t cls;

    trace_char_class u_cls (
        .char (char),
        .cls  (cls)
    );

    // Next state and datapath strobes. Anything not explicitly accepted
    // drops the line back to IDLE.
    always_comb begin
        state_d  = IDLE;
        clr      = 1'b0;
        cnt_clr  = 1'b0;
        set_mem  = 1'b0;
        load     = 1'b0;
        acc_time = 1'b0;
        acc_grf  = 1'b0;
        acc_pc   = 1'b0;
        acc_addr = 1'b0;
        acc_data = 1'b0;
        if (char == CH_CARET) begin
            state_d = TIME;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                TIME: begin
                    if (cls.is_dec && cnt_q < TIME_MAX) begin
                        state_d  = TIME;
                        acc_time = 1'b1;
                    end else if (char == CH_AT && cnt_q != '0) begin
                        state_d = PC;
                        cnt_clr = 1'b1;
                    end
                end
                PC: begin
                    if (cls.is_hex && cnt_q < HEX_CNT) begin
                        state_d = PC;
                        acc_pc  = 1'b1;
                    end else if (char == CH_COLON && cnt_q == HEX_CNT) begin
                        state_d = COLON_SP;
                    end
                end
                COLON_SP: begin
                    if (cls.is_space) begin
                        state_d = COLON_SP;
                    end else if (char == CH_DOLLAR) begin
                        state_d = GRF;
                        cnt_clr = 1'b1;
                    end else if (char == CH_STAR) begin
                        state_d = ADDR;
                        cnt_clr = 1'b1;
                        set_mem = 1'b1;
                    end
                end
                GRF: begin
                    if (cls.is_dec && cnt_q < GRF_MAX) begin
                        state_d = GRF;
                        acc_grf = 1'b1;
                    end else if (cls.is_space && cnt_q != '0) begin
                        state_d = SP_LT;
                    end else if (char == CH_LT && cnt_q != '0) begin
                        state_d = EQ;
                    end
                end
                ADDR: begin
                    if (cls.is_hex && cnt_q < HEX_CNT) begin
                        state_d  = ADDR;
                        acc_addr = 1'b1;
                    end else if (cls.is_space && cnt_q == HEX_CNT) begin
                        state_d = SP_LT;
                    end else if (char == CH_LT && cnt_q == HEX_CNT) begin
                        state_d = EQ;
                    end
                end
                SP_LT: begin
                    if (cls.is_space)     state_d = SP_LT;
                    else if (char == CH_LT) state_d = EQ;
                end
                EQ: begin
                    if (char == CH_EQ) begin
                        state_d = DATA_SP;
                        cnt_clr = 1'b1;
                    end
                end
                DATA_SP: begin
                    if (cls.is_space) begin
                        state_d = DATA_SP;
                    end else if (cls.is_hex) begin
                        state_d  = DATA;
                        acc_data = 1'b1;
                    end
                end
                DATA: begin
                    if (cls.is_hex && cnt_q < HEX_CNT) begin
                        state_d  = DATA;
                        acc_data = 1'b1;
                    end else if (char == CH_HASH && cnt_q == HEX_CNT) begin
                        state_d = DONE;
                        load    = 1'b1;
                    end
                end
                default: state_d = IDLE; // IDLE, DONE
            endcase
        end
    end

    assign acc_any = acc_time | acc_grf | acc_pc | acc_addr | acc_data;

`ifdef TRACE_CHECK_EN
    localparam logic [HW-1:0] PC_LO_W   = HW'(PC_LO);
    localparam logic [HW-1:0] PC_HI_W   = HW'(PC_HI);
    localparam logic [HW-1:0] ADDR_LO_W = HW'(ADDR_LO);
    localparam logic [HW-1:0] ADDR_HI_W = HW'(ADDR_HI);

    logic pc_in, addr_in;

    // Inclusive range tests written with an appended bit so that a zero
    // lower bound does not turn into an always-true unsigned compare.
    always_comb begin
        pc_in   = ({pc_acc, 1'b1}   > {PC_LO_W, 1'b0})   && ({pc_acc, 1'b0}   < {PC_HI_W, 1'b1});
        addr_in = ({addr_acc, 1'b1} > {ADDR_LO_W, 1'b0}) && ({addr_acc, 1'b0} < {ADDR_HI_W, 1'b1});
        err_d               = '0;
        err_d[ERR_PC_ALIGN] = (pc_acc[1:0] != 2'b00);
        err_d[ERR_PC_RANGE] = !pc_in;
        err_d[ERR_MEM]      = is_mem_q && ((addr_acc[1:0] != 2'b00) || !addr_in);
        err_d[ERR_GRF]      = !is_mem_q && (grf_acc > GW'(31));
    end
`else
    assign err_d = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            time_acc    <= '0;
            grf_acc     <= '0;
            pc_acc      <= '0;
            addr_acc    <= '0;
            data_acc    <= '0;
            is_mem_q    <= 1'b0;
            format_type <= FORMAT_NONE;
            error_code  <= '0;
            time_o      <= '0;
            pc_o        <= '0;
            grf_o       <= '0;
            addr_o      <= '0;
            data_o      <= '0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                // The unused field of the form (grf or addr) stays 0 from here.
                cnt_q    <= '0;
                time_acc <= '0;
                grf_acc  <= '0;
                pc_acc   <= '0;
                addr_acc <= '0;
                data_acc <= '0;
                is_mem_q <= 1'b0;
            end else begin
                if (cnt_clr)      cnt_q <= '0;
                else if (acc_any) cnt_q <= cnt_q + CW'(1);
                if (acc_time) time_acc <= time_acc * TW'(10) + TW'(cls.nibble);
                if (acc_grf)  grf_acc  <= grf_acc  * GW'(10) + GW'(cls.nibble);
                if (acc_pc)   pc_acc   <= {pc_acc[HW-5:0],   cls.nibble};
                if (acc_addr) addr_acc <= {addr_acc[HW-5:0], cls.nibble};
                if (acc_data) data_acc <= {data_acc[HW-5:0], cls.nibble};
                if (set_mem)  is_mem_q <= 1'b1;
            end
            // format_type/error_code are nonzero only for the DONE cycle.
            format_type <= load ? (is_mem_q ? FORMAT_MEM : FORMAT_REG) : FORMAT_NONE;
            error_code  <= load ? err_d : 4'd0;
            if (load) begin
                time_o <= time_acc;
                pc_o   <= pc_acc;
                grf_o  <= grf_acc;
                addr_o <= addr_acc;
                data_o <= data_acc;
            end
        end
    end

endmodule

// File: tb/tb_trace_line_checker.sv
// Directed bench for trace_line_checker: hand-computed expectations for
// accepted lines, rejects, restart, back-to-back lines and mid-line reset.
module tb_trace_line_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char;
    logic [1:0]  format_type;
    logic [3:0]  error_code;
    logic [13:0] time_o;
    logic [31:0] pc_o;
    logic [13:0] grf_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;

    int n_checks = 0;
    int n_errors = 0;
    int pulses;

`ifdef TRACE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    trace_line_checker dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char),
        .format_type (format_type),
        .error_code  (error_code),
        .time_o      (time_o),
        .pc_o        (pc_o),
        .grf_o       (grf_o),
        .addr_o      (addr_o),
        .data_o      (data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive at negedge; count cycles where format_type was nonzero.
    task automatic drive_chars(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            if (format_type != 2'd0) pulses++;
            char = s[i];
        end
    endtask

    // Leaves the caller in the cycle right after '#' was sampled.
    task automatic run_line(input string s);
        pulses = 0;
        drive_chars(s);
        @(negedge clk);
        if (format_type != 2'd0) pulses++;
        char = 8'h20;
    endtask

    string rej [7] = '{
        "^12345@00003000: $1 <= 00000000#",
        "^1@00003000: $1 2 <= 00000000#",
        "^1@00003000: $1 < = 00000000#",
        "^1@0003000: $1 <= 00000000#",
        "^1@00003A00: $1 <= 00000000#",
        "^1@00003000: $<= 00000000#",
        "^1@00003000: $1 <= 000000001#"
    };

    initial begin
        reset = 1'b1;
        char  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_fmt",  format_type, 0);
        check("rst_err",  error_code, 0);
        check("rst_time", time_o, 0);
        check("rst_pc",   pc_o, 0);
        check("rst_data", data_o, 0);
        reset = 1'b0;

        run_line("^12@00003000: $3 <= 0000000a#");
        check("l1_fmt",    format_type, 1);
        check("l1_time",   time_o, 12);
        check("l1_pc",     pc_o, 'h3000);
        check("l1_grf",    grf_o, 3);
        check("l1_addr",   addr_o, 0);
        check("l1_data",   data_o, 'ha);
        check("l1_err",    error_code, 0);
        check("l1_pulses", pulses, 1);
        @(negedge clk);
        check("l1_fmt_drop", format_type, 0);
        check("l1_err_drop", error_code, 0);
        check("l1_hold",     data_o, 'ha);

        run_line("^7@00003002: *00000004 <=00000001#");
        check("l2_fmt",  format_type, 2);
        check("l2_addr", addr_o, 4);
        check("l2_grf",  grf_o, 0);
        check("l2_data", data_o, 1);
        check("l2_err",  error_code, CHK ? 4'b0001 : 4'b0000);

        run_line("^9@00003004:$40<= 00000001#");
        check("l3_fmt", format_type, 1);
        check("l3_grf", grf_o, 40);
        check("l3_err", error_code, CHK ? 4'b1000 : 4'b0000);

        run_line("^9@00008000: *00003000 <= 00000000#");
        check("l4_fmt", format_type, 2);
        check("l4_pc",  pc_o, 'h8000);
        check("l4_err", error_code, CHK ? 4'b0110 : 4'b0000);

        // Top of every range, all fields at their widest.
        run_line("^9999@00006ffc: *00002ffc <= ffffffff#");
        check("bnd_fmt",  format_type, 2);
        check("bnd_time", time_o, 9999);
        check("bnd_pc",   pc_o, 'h6ffc);
        check("bnd_addr", addr_o, 'h2ffc);
        check("bnd_data", data_o, 'hffffffff);
        check("bnd_err",  error_code, 0);

        for (int r = 0; r < 7; r++) begin
            run_line(rej[r]);
            check($sformatf("rej%0d_pulses", r), pulses, 0);
        end
        check("rej_hold_data", data_o, 'hffffffff);
        check("rej_hold_time", time_o, 9999);

        run_line("^1@000^2@00003000: $1 <= 00000000#");
        check("rst_line_fmt",  format_type, 1);
        check("rst_line_time", time_o, 2);
        check("rst_line_grf",  grf_o, 1);

        // '^' arriving in DONE starts the next line on the same edge.
        run_line("^1@00003000: $1 <= 00000001#^2@00003004: $2 <= 00000002#");
        check("b2b_pulses", pulses, 2);
        check("b2b_time",   time_o, 2);
        check("b2b_pc",     pc_o, 'h3004);
        check("b2b_data",   data_o, 2);

        drive_chars("^5@00003000: $");
        @(negedge clk);
        reset = 1'b1;
        char  = "1";
        @(negedge clk);
        check("mid_rst_time", time_o, 0);
        check("mid_rst_fmt",  format_type, 0);
        reset = 1'b0;
        run_line("2 <= 00000000#");
        check("mid_rst_pulses", pulses, 0);
        run_line("^3@00003008: $4 <= 00000004#");
        check("post_rst_fmt",  format_type, 1);
        check("post_rst_time", time_o, 3);
        check("post_rst_grf",  grf_o, 4);
        check("post_rst_pc",   pc_o, 'h3008);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
